// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared types and constants for the SPI target
package spi_target_pkg;

    typedef enum logic {IDLE, SHIFT} state_e;

    localparam int BitCntW = 3;
    localparam logic [7:0] DefaultIdleByte = 8'hFF;

    function automatic logic out_bit(input logic [7:0] v, input bit msb_first);
        return msb_first ? v[7] : v[0];
    endfunction

endpackage

// File: rtl/spi_target_edge_det.sv
// rtl/spi_target_edge_det.sv - synchroniser plus rise/fall pulse generation for one async input
module spi_target_edge_det #(
    parameter int SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SyncStages-1:0] sync_q;
    logic                  prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], d_i};
            prev_q <= sync_q[SyncStages-1];
        end
    end

    assign rise_o = sync_q[SyncStages-1] & ~prev_q;
    assign fall_o = ~sync_q[SyncStages-1] & prev_q;

endmodule

// File: rtl/spi_target_dev.sv
// rtl/spi_target_dev.sv - SPI mode-0 target, oversampled pins, valid/ready byte interfaces
module spi_target_dev
    import spi_target_pkg::*;
#(
    parameter int         SyncStages = 2,
    parameter bit         MsbFirst   = 1'b1,
    parameter logic [7:0] IdleByte   = DefaultIdleByte
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_sck_i,
    input  logic       spi_cs_ni,
    input  logic       spi_copi_i,
    output logic       spi_cipo_o,
    output logic       spi_cipo_en_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       rx_overflow_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_underflow_o,
    output logic       active_o
);

    logic                  sck_rise, sck_fall, cs_rise, cs_fall;
    logic [SyncStages-1:0] copi_sync;
    logic                  copi;
    state_e                state, state_next;
    logic [BitCntW-1:0]    bit_cnt;
    logic [7:0]            rx_shift, tx_shift, tx_load, tx_shifted;
    logic                  byte_done, start, load, tx_step, rx_step, abort;

    spi_target_edge_det #(.SyncStages(SyncStages)) u_sck_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (spi_sck_i),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_target_edge_det #(.SyncStages(SyncStages)) u_cs_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (spi_cs_ni),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // COPI needs the same depth as SCK so the sampled bit lines up with sck_rise
    always_ff @(posedge clk_i) begin
        if (rst_i) copi_sync <= '0;
        else       copi_sync <= {copi_sync[SyncStages-2:0], spi_copi_i};
    end
    assign copi = copi_sync[SyncStages-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        load       = 1'b0;
        tx_step    = 1'b0;
        rx_step    = 1'b0;
        abort      = 1'b0;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_next = SHIFT;
                        start      = 1'b1;
                        load       = 1'b1;
                    end
                end
                SHIFT: begin
                    // deselect takes priority over any SCK edge landing in the same cycle
                    if (cs_rise) begin
                        state_next = IDLE;
                        abort      = 1'b1;
                    end else begin
                        rx_step = sck_rise;
                        if (sck_fall) begin
                            if (bit_cnt == '0) load    = 1'b1;
                            else               tx_step = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign tx_load        = tx_valid_i ? tx_data_i : IdleByte;
    assign tx_shifted     = MsbFirst ? {tx_shift[6:0], 1'b0} : {1'b0, tx_shift[7:1]};
    assign tx_ready_o     = load & tx_valid_i;
    assign tx_underflow_o = load & ~tx_valid_i;
    assign active_o       = (state == SHIFT);
    assign rx_overflow_o  = byte_done & rx_valid_o & ~rx_ready_i & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            byte_done     <= 1'b0;
            spi_cipo_o    <= 1'b1;
            spi_cipo_en_o <= 1'b0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
        end else begin
            byte_done <= rx_step && (bit_cnt == '1);

            if (load) begin
                tx_shift   <= tx_load;
                spi_cipo_o <= out_bit(tx_load, MsbFirst);
            end else if (tx_step) begin
                tx_shift   <= tx_shifted;
                spi_cipo_o <= out_bit(tx_shifted, MsbFirst);
            end

            if (start) begin
                bit_cnt       <= '0;
                spi_cipo_en_o <= 1'b1;
            end

            if (abort) begin
                bit_cnt       <= '0;
                spi_cipo_en_o <= 1'b0;
                spi_cipo_o    <= 1'b1;
            end

            if (rx_step) begin
                rx_shift <= MsbFirst ? {rx_shift[6:0], copi} : {copi, rx_shift[7:1]};
                bit_cnt  <= bit_cnt + BitCntW'(1);
            end

            // completed byte is handed over one cycle after its last bit lands in rx_shift
            if (byte_done && (!rx_valid_o || rx_ready_i)) begin
                rx_data_o  <= rx_shift;
                rx_valid_o <= 1'b1;
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_target_dev.sv
// tb/tb_spi_target_dev.sv - directed bench for spi_target_dev (MSB-first and LSB-first instances)
module tb_spi_target_dev;

    logic       clk = 1'b0, rst = 1'b1;
    logic       sck = 1'b0, copi = 1'b0, cs_n = 1'b1, l_cs_n = 1'b1;
    logic       cipo, cipo_en, rx_valid, rx_overflow, tx_ready, tx_underflow, active;
    logic       rx_ready = 1'b0, tx_valid = 1'b0;
    logic [7:0] rx_data, tx_data;
    logic       l_cipo, l_cipo_en, l_rx_valid, l_rx_overflow, l_tx_ready, l_tx_underflow, l_active;
    logic [7:0] l_rx_data;
    logic       l_rx_ready = 1'b0, l_tx_valid = 1'b1;
    logic [7:0] l_tx_data = 8'h80;

    logic [7:0] tx_tab [0:7];
    logic [2:0] tx_ptr = 3'd0;
    logic [7:0] host_tx [0:3];
    logic [7:0] host_rx [0:3];

    int cyc = 0;
    int checks = 0, errors = 0;
    int n_txr = 0, n_unf = 0, n_ovf = 0;
    int txr_cyc = 0, ovf_cyc = 0, rxv_rise_cyc = 0;
    int cs_fall_cyc = 0, last_rise_cyc = 0;
    logic rxv_prev = 1'b0, en_seen = 1'b0;
    logic [7:0] rxq [$];

    spi_target_dev #(.SyncStages(2), .MsbFirst(1'b1), .IdleByte(8'hFF)) dut (
        .clk_i(clk), .rst_i(rst), .spi_sck_i(sck), .spi_cs_ni(cs_n), .spi_copi_i(copi),
        .spi_cipo_o(cipo), .spi_cipo_en_o(cipo_en), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .rx_ready_i(rx_ready), .rx_overflow_o(rx_overflow), .tx_data_i(tx_data),
        .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_underflow_o(tx_underflow),
        .active_o(active)
    );

    spi_target_dev #(.SyncStages(2), .MsbFirst(1'b0), .IdleByte(8'hFF)) dut_lsb (
        .clk_i(clk), .rst_i(rst), .spi_sck_i(sck), .spi_cs_ni(l_cs_n), .spi_copi_i(copi),
        .spi_cipo_o(l_cipo), .spi_cipo_en_o(l_cipo_en), .rx_data_o(l_rx_data),
        .rx_valid_o(l_rx_valid), .rx_ready_i(l_rx_ready), .rx_overflow_o(l_rx_overflow),
        .tx_data_i(l_tx_data), .tx_valid_i(l_tx_valid), .tx_ready_o(l_tx_ready),
        .tx_underflow_o(l_tx_underflow), .active_o(l_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // TX source: advances to the next table entry whenever a byte is taken
    always @(posedge clk) if (tx_ready) tx_ptr <= tx_ptr + 3'd1;
    assign tx_data = tx_tab[tx_ptr];

    always @(negedge clk) begin
        #1;
        if (tx_ready) begin n_txr++; txr_cyc = cyc; end
        if (tx_underflow) n_unf++;
        if (rx_overflow) begin n_ovf++; ovf_cyc = cyc; end
        if (rx_valid && !rxv_prev) rxv_rise_cyc = cyc;
        rxv_prev = rx_valid;
        if (rx_valid && rx_ready) rxq.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SCK = clk/8; final SCK fall coincides with CS_N rise
    task automatic spi_frame(input int nbits, input bit lsb);
        if (lsb) l_cs_n = 1'b0;
        else     cs_n = 1'b0;
        cs_fall_cyc = cyc;
        for (int k = 0; k < nbits; k++) begin
            int j;
            int idx;
            j   = k / 8;
            idx = lsb ? (k % 8) : (7 - (k % 8));
            copi = host_tx[j][idx];
            repeat (4) @(negedge clk);
            host_rx[j][idx] = lsb ? l_cipo : cipo;
            if (k == 0) en_seen = lsb ? l_cipo_en : cipo_en;
            sck = 1'b1;
            last_rise_cyc = cyc;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            if (k == nbits - 1) begin
                cs_n   = 1'b1;
                l_cs_n = 1'b1;
            end
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int base_txr, base_unf, base_ovf, base_q;
        tx_tab[0] = 8'hA5; tx_tab[1] = 8'h10; tx_tab[2] = 8'h20; tx_tab[3] = 8'h30;
        for (int i = 4; i < 8; i++) tx_tab[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin host_tx[i] = 8'h00; host_rx[i] = 8'h00; end

        repeat (3) @(negedge clk);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_active", active, 1'b0);
        check("rst_cipo", cipo, 1'b1);
        check("rst_cipo_en", cipo_en, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_tx_underflow", tx_underflow, 1'b0);
        check("rst_rx_overflow", rx_overflow, 1'b0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // single byte, MSB first
        tx_valid = 1'b1; host_tx[0] = 8'h3C;
        base_txr = n_txr; base_unf = n_unf;
        spi_frame(8, 1'b0);
        check("t1_rx_data", rx_data, 8'h3C);
        check("t1_rx_valid", rx_valid, 1'b1);
        check("t1_host_rx", host_rx[0], 8'hA5);
        check("t1_tx_ready_count", n_txr - base_txr, 1);
        check("t1_tx_ready_at_cs_fall", txr_cyc - cs_fall_cyc, 2);
        check("t1_rx_latency", rxv_rise_cyc - last_rise_cyc, 4);
        check("t1_no_underflow", n_unf - base_unf, 0);
        check("t1_cipo_en_in_frame", en_seen, 1'b1);
        check("t1_cipo_en_after", cipo_en, 1'b0);
        check("t1_active_after", active, 1'b0);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        check("t1_rx_valid_consumed", rx_valid, 1'b0);

        // back-to-back bytes
        rx_ready = 1'b1;
        base_q = rxq.size(); base_txr = n_txr;
        host_tx[0] = 8'h01; host_tx[1] = 8'h02; host_tx[2] = 8'h03;
        spi_frame(24, 1'b0);
        check("t2_rx_count", rxq.size() - base_q, 3);
        for (int k = 0; k < 3; k++)
            check($sformatf("t2_rx_byte%0d", k),
                  (base_q + k < rxq.size()) ? {24'h0, rxq[base_q + k]} : 32'hDEAD, k + 1);
        check("t2_host_rx0", host_rx[0], 8'h10);
        check("t2_host_rx1", host_rx[1], 8'h20);
        check("t2_host_rx2", host_rx[2], 8'h30);
        check("t2_tx_ready_count", n_txr - base_txr, 3);

        // TX underflow
        tx_valid = 1'b0;
        base_txr = n_txr; base_unf = n_unf;
        host_tx[0] = 8'h00; host_tx[1] = 8'h00;
        spi_frame(16, 1'b0);
        check("t3_host_rx0", host_rx[0], 8'hFF);
        check("t3_host_rx1", host_rx[1], 8'hFF);
        check("t3_underflow_count", n_unf - base_unf, 2);
        check("t3_tx_ready_count", n_txr - base_txr, 0);
        rx_ready = 1'b0;
        @(negedge clk);

        // RX overflow
        base_ovf = n_ovf;
        host_tx[0] = 8'hAA; host_tx[1] = 8'h55;
        spi_frame(16, 1'b0);
        check("t4_rx_data_kept", rx_data, 8'hAA);
        check("t4_rx_valid", rx_valid, 1'b1);
        check("t4_overflow_count", n_ovf - base_ovf, 1);
        check("t4_overflow_at_2nd_byte", ovf_cyc - last_rise_cyc, 3);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);

        // abort after 5 bits, then a full frame
        host_tx[0] = 8'hC3;
        spi_frame(5, 1'b0);
        check("t5_no_partial_valid", rx_valid, 1'b0);
        check("t5_cipo_en_between", cipo_en, 1'b0);
        check("t5_cipo_idle", cipo, 1'b1);
        check("t5_active_between", active, 1'b0);
        spi_frame(8, 1'b0);
        check("t5_rx_data", rx_data, 8'hC3);
        check("t5_rx_valid", rx_valid, 1'b1);
        check("t5_cipo_en_in_frame", en_seen, 1'b1);

        // reset mid-byte with a byte held
        host_tx[0] = 8'h5A;
        fork
            spi_frame(8, 1'b0);
            begin
                repeat (30) @(negedge clk);
                check("t6_active_before", active, 1'b1);
                check("t6_rx_valid_before", rx_valid, 1'b1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("t6_rx_valid", rx_valid, 1'b0);
                check("t6_active", active, 1'b0);
                check("t6_cipo", cipo, 1'b1);
                check("t6_cipo_en", cipo_en, 1'b0);
            end
        join
        check("t6_no_delivery_after", rx_valid, 1'b0);
        check("t6_idle_after", active, 1'b0);

        // LSB-first instance
        host_tx[0] = 8'h01;
        spi_frame(8, 1'b1);
        check("t7_lsb_rx_data", l_rx_data, 8'h01);
        check("t7_lsb_rx_valid", l_rx_valid, 1'b1);
        check("t7_lsb_host_rx", host_rx[0], 8'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
